// File: rtl/cross_connect_port_lookup.sv
// cross_connect_port_lookup: buffers the arbiter word stream and rewrites
// the IOQ module header dst-port field from the packet's source port.
module cross_connect_port_lookup #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_MAC_PORTS = 4,
  parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM = 8'hFF,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [31:0]           pkt_cnt,
  output logic                  hdr_err
);

  localparam int CW = FIFO_DEPTH_BITS + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] NF_CNT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE = FIFO_DEPTH_BITS'(1);
  localparam logic [15:0] MAC_LIMIT = 16'(2 * NUM_MAC_PORTS);

  typedef enum logic {MODULE_HDRS, IN_PKT} state_t;

  state_t state;
  logic   ioq_seen;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [CTRL_WIDTH-1:0] mem_ctrl [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic                  wr_en;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  head_is_ioq;
  logic [15:0]           src;
  logic [15:0]           dst;
  logic [DATA_WIDTH-1:0] fwd_data;

  assign in_rdy = count < NF_CNT;
  assign wr_en = in_wr && (count != FULL_CNT);
  assign pop = (count != '0) && out_rdy;

  assign head_data = mem_data[rd_ptr];
  assign head_ctrl = mem_ctrl[rd_ptr];
  assign head_is_ioq = (state == MODULE_HDRS) &&
                       (head_ctrl == IOQ_STAGE_NUM);
  assign src = head_data[31:16];

  // Even ports are MACs (paired 0<->1, 2<->3); odd ports are CPU queues.
  always_comb begin
    dst = '0;
    if (src < MAC_LIMIT) begin
      if (src[0])
        dst = 16'd1 << (src - 16'd1);
      else
        dst = 16'd1 << (src ^ 16'd2);
    end
  end

  always_comb begin
    fwd_data = head_data;
    if (head_is_ioq)
      fwd_data[DATA_WIDTH-1 -: 16] = dst;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= in_data;
      mem_ctrl[wr_ptr] <= in_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
      pkt_cnt  <= '0;
      hdr_err  <= 1'b0;
      state    <= MODULE_HDRS;
      ioq_seen <= 1'b0;
    end else begin
      out_wr  <= pop;
      hdr_err <= 1'b0;
      if (pop) begin
        out_data <= fwd_data;
        out_ctrl <= head_ctrl;
        unique case (state)
          MODULE_HDRS: begin
            if (head_ctrl == '0) begin
              state   <= IN_PKT;
              hdr_err <= !ioq_seen;
            end else if (head_is_ioq) begin
              ioq_seen <= 1'b1;
            end
          end
          IN_PKT: begin
            if (head_ctrl != '0) begin
              state    <= MODULE_HDRS;
              ioq_seen <= 1'b0;
              if (pkt_cnt != 32'hFFFF_FFFF)
                pkt_cnt <= pkt_cnt + 32'd1;
            end
          end
          default: state <= MODULE_HDRS;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cross_connect_port_lookup.sv
// tb_cross_connect_port_lookup: random and directed packets checked
// against a packet-level reference of the port lookup.
module tb_cross_connect_port_lookup;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic [31:0] pkt_cnt;
  logic        hdr_err;

  cross_connect_port_lookup dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_rdy(out_rdy),
    .pkt_cnt(pkt_cnt), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ctrl;
    bit          err;
    bit          eop;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  int cyc = 0;
  int t_lat = -1;
  bit rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Spec port map: MAC pairs swap, CPU i goes to MAC i, others to nowhere.
  function automatic logic [15:0] ref_dst(input int p);
    int mac;
    if (p >= 8) return 16'h0;
    mac = p / 2;
    if (p % 2 == 1) return 16'(1 << (2 * mac));
    return 16'(1 << (2 * (mac % 2 == 0 ? mac + 1 : mac - 1)));
  endfunction

  task automatic put(input logic [63:0] d, input logic [7:0] c,
                     input bit nowait);
    int g = 0;
    while (!nowait && !in_rdy && g < 200) begin
      in_wr = 1'b0;
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("in_rdy_timeout", 64'd0, 64'd1);
    in_data = d;
    in_ctrl = c;
    in_wr = 1'b1;
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic emit(input logic [63:0] d, input logic [7:0] c,
                      input logic [63:0] e, input bit err,
                      input bit eop);
    exp_t x;
    x.data = e; x.ctrl = c; x.err = err; x.eop = eop;
    exp_q.push_back(x);
    put(d, c, 1'b0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic hdr_word(input logic [7:0] c, input int src,
                          inout bit ioq);
    logic [63:0] d, e;
    d = rnd64();
    d[31:16] = 16'(src);
    e = d;
    if (c == 8'hFF) begin
      ioq = 1'b1;
      e[63:48] = ref_dst(src);
    end
    emit(d, c, e, 1'b0, 1'b0);
  endtask

  task automatic body(input int nd, input bit ioq);
    logic [63:0] d;
    logic [7:0] c;
    for (int i = 0; i < nd; i++) begin
      d = rnd64();
      emit(d, 8'h00, d, (i == 0) && !ioq, 1'b0);
    end
    d = rnd64();
    c = 8'($urandom_range(1, 255));
    emit(d, c, d, 1'b0, 1'b1);
  endtask

  task automatic send_pkt(input logic [7:0] hc, input int src,
                          input int nd);
    bit ioq = 1'b0;
    hdr_word(hc, src, ioq);
    body(nd, ioq);
  endtask

  task automatic rand_pkt();
    bit ioq = 1'b0;
    int nh = $urandom_range(0, 2);
    logic [7:0] c;
    for (int h = 0; h < nh; h++) begin
      case ($urandom_range(0, 2))
        0: c = 8'h02;
        1: c = 8'h10;
        default: c = 8'hFF;
      endcase
      hdr_word(c, $urandom_range(0, 11), ioq);
    end
    body($urandom_range(1, 4), ioq);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Output monitor: every emitted word must match the expected stream.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset && out_wr) begin
        if (t_lat >= 0) begin
          chk("latency", 64'(cyc - t_lat), 64'd2);
          t_lat = -1;
        end
        if (exp_q.size() == 0) begin
          chk("extra_word", {8'h0, out_ctrl, out_data[47:0]}, 64'd0);
        end else begin
          x = exp_q.pop_front();
          chk("out_data", out_data, x.data);
          chk("out_ctrl", 64'(out_ctrl), 64'(x.ctrl));
          chk("hdr_err", 64'(hdr_err), 64'(x.err));
          if (x.eop) begin
            model_cnt++;
            chk("pkt_cnt", 64'(pkt_cnt), 64'(model_cnt));
          end
        end
      end else if (!reset && hdr_err) begin
        chk("stray_hdr_err", 64'(hdr_err), 64'd0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int g;
    // reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_hdr_err", 64'(hdr_err), 64'd0);
    chk("rst_out_data", out_data, 64'd0);

    // basic packet with latency measurement
    t_lat = cyc;
    send_pkt(8'hFF, 0, 3);
    repeat (4) @(negedge clk);

    // CPU source and out-of-range source
    send_pkt(8'hFF, 3, 2);
    send_pkt(8'hFF, 9, 1);
    repeat (4) @(negedge clk);

    // backpressure: three words fill to nearly_full, fourth absorbed
    out_rdy = 1'b0;
    begin
      logic [63:0] d [5];
      logic [7:0]  c [5];
      exp_t x;
      for (int i = 0; i < 5; i++) d[i] = rnd64();
      d[0][31:16] = 16'd6;
      c[0] = 8'hFF; c[1] = 8'h00; c[2] = 8'h00; c[3] = 8'h00;
      c[4] = 8'h40;
      for (int i = 0; i < 5; i++) begin
        x.data = d[i]; x.ctrl = c[i];
        x.err = 1'b0; x.eop = (i == 4);
        if (i == 0) x.data[63:48] = ref_dst(6);
        exp_q.push_back(x);
      end
      for (int i = 0; i < 3; i++) begin
        chk("bp_in_rdy_hi", 64'(in_rdy), 64'd1);
        put(d[i], c[i], 1'b1);
      end
      chk("bp_in_rdy_lo", 64'(in_rdy), 64'd0);
      put(d[3], c[3], 1'b1);
      @(negedge clk);
      chk("bp_no_out", 64'(out_wr), 64'd0);
      out_rdy = 1'b1;
      put(d[4], c[4], 1'b0);
    end
    repeat (6) @(negedge clk);

    // packet without IOQ header
    send_pkt(8'h02, 0, 2);
    repeat (4) @(negedge clk);

    // reset in the middle of a packet
    out_rdy = 1'b0;
    put(rnd64(), 8'hFF, 1'b0);
    put(rnd64(), 8'h00, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    model_cnt = 0;
    reset = 1'b0;
    out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_in_rdy", 64'(in_rdy), 64'd1);
    send_pkt(8'hFF, 2, 2);
    repeat (4) @(negedge clk);

    // random traffic with random backpressure
    rand_rdy = 1'b1;
    repeat (60) rand_pkt();
    rand_rdy = 1'b0;
    out_rdy = 1'b1;

    g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
